// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - register-file write port arbiter: pipeline first, auxiliary writes queued (optional WB_CANCEL_CNT_EN cancel counter)
module wb_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_wr,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_addr,
    input  logic [31:0] aux_data,
    output logic        rf_wr,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    input  logic [4:0]  rd_addr1,
    input  logic [4:0]  rd_addr2,
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [31:0] fwd1_data,
    output logic [31:0] fwd2_data,
    output logic        busy1,
    output logic        busy2,
    output logic [15:0] cancel_cnt
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // Queue storage: address/data payload plus occupancy and live (not superseded) flags.
    logic [4:0]       q_addr [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [DEPTH-1:0] q_live;

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    logic             full;
    logic             head_exists;
    logic             pipe_issue;
    logic             pop;
    logic             push;
    logic [DEPTH-1:0] kill_vec;
    logic             busy1_c;
    logic             busy2_c;

    assign full        = (count == FULL_CNT);
    assign head_exists = (count != '0);
    assign aux_ready   = !full;

    // Writes to r0 are architectural no-ops: the pipe does not issue, the aux handshakes but is dropped.
    assign pipe_issue  = pipe_wr && (pipe_addr != 5'd0);
    assign pop         = !pipe_issue && head_exists;
    assign push        = aux_valid && aux_ready && (aux_addr != 5'd0);

    // A pipeline write supersedes every older queued write to the same register.
    always_comb begin
        kill_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_issue && q_valid[i] && q_live[i] && (q_addr[i] == pipe_addr)) begin
                kill_vec[i] = 1'b1;
            end
        end
    end

    // Decode must stall on any register still owed a live queued write, including the head being issued now.
    always_comb begin
        busy1_c = 1'b0;
        busy2_c = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && q_live[i] && (q_addr[i] == rd_addr1)) begin
                busy1_c = 1'b1;
            end
            if (q_valid[i] && q_live[i] && (q_addr[i] == rd_addr2)) begin
                busy2_c = 1'b1;
            end
        end
    end

    assign busy1     = busy1_c && (rd_addr1 != 5'd0);
    assign busy2     = busy2_c && (rd_addr2 != 5'd0);

    assign fwd1_hit  = rf_wr && (rf_addr == rd_addr1) && (rd_addr1 != 5'd0);
    assign fwd2_hit  = rf_wr && (rf_addr == rd_addr2) && (rd_addr2 != 5'd0);
    assign fwd1_data = rf_data;
    assign fwd2_data = rf_data;

    // Payload RAM has no reset; occupancy flags alone decide whether an entry means anything.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= aux_addr;
            q_data[wr_ptr] <= aux_data;
        end
    end

    // Queue control: pointers, count, occupancy and live flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            q_valid <= '0;
            q_live  <= '0;
        end else begin
            // Killed entries stay queued so they still consume their issue slot in order.
            q_live <= q_live & ~kill_vec;
            if (pop) begin
                q_valid[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            // The freshly pushed slot was empty, so a same-edge kill can never touch it.
            if (push) begin
                q_valid[wr_ptr] <= 1'b1;
                q_live[wr_ptr]  <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered write port: pipeline, then queue head (silent if killed), else idle with address/data held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_wr   <= 1'b0;
            rf_addr <= 5'd0;
            rf_data <= 32'd0;
        end else if (pipe_issue) begin
            rf_wr   <= 1'b1;
            rf_addr <= pipe_addr;
            rf_data <= pipe_data;
        end else if (pop && q_live[rd_ptr]) begin
            rf_wr   <= 1'b1;
            rf_addr <= q_addr[rd_ptr];
            rf_data <= q_data[rd_ptr];
        end else begin
            rf_wr   <= 1'b0;
        end
    end

`ifdef WB_CANCEL_CNT_EN
    logic [AW:0]  kill_num;
    logic [16:0]  cancel_sum;
    logic [15:0]  cancel_q;

    // Population count of entries superseded at this edge.
    always_comb begin
        kill_num = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kill_num = kill_num + {{AW{1'b0}}, kill_vec[i]};
        end
    end

    assign cancel_sum = {1'b0, cancel_q} + 17'(kill_num);

    // Saturating cancel counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cancel_q <= 16'h0000;
        end else if (cancel_sum[16]) begin
            cancel_q <= 16'hFFFF;
        end else begin
            cancel_q <= cancel_sum[15:0];
        end
    end

    assign cancel_cnt = cancel_q;
`else
    assign cancel_cnt = 16'h0000;
`endif

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Writer side of the pipeline register file. It merges two write sources onto the single register-file write port: the in-order MEM/WB pipeline result and a long-latency auxiliary unit (multiply/divide, future load-miss return).
- The pipeline source always wins. Auxiliary writes wait in a small FIFO.
- Provides forwarding and busy indications to the decode-stage readers so they never observe a stale or not-yet-written value.

Parameters:
- DEPTH, 4, auxiliary FIFO entries; power of two, at least 2.
- AW, 2, log2(DEPTH); index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- pipe_wr  in  1  pipeline writeback request, this cycle
- pipe_addr  in  5  pipeline destination register
- pipe_data  in  32  pipeline write data
- aux_valid  in  1  auxiliary write offered
- aux_ready  out  1  auxiliary write accepted when aux_valid && aux_ready at posedge
- aux_addr  in  5  auxiliary destination register
- aux_data  in  32  auxiliary write data
- rf_wr  out  1  register-file write enable (registered)
- rf_addr  out  5  register-file write address (registered)
- rf_data  out  32  register-file write data (registered)
- rd_addr1, rd_addr2  in  5 each  decode read addresses
- fwd1_hit, fwd2_hit  out  1 each  read address matches the in-flight rf write
- fwd1_data, fwd2_data  out  32 each  forwarded value (rf_data)
- busy1, busy2  out  1 each  read address has a live queued auxiliary write; decode must stall
- cancel_cnt  out  16  cancelled-entry counter (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-low, immediate):
  - FIFO empty; all entry valid/live bits cleared.
  - rf_wr=0, rf_addr=0, rf_data=0, cancel_cnt=0.
  - Reset mid-operation discards all queued entries with no write issued.
- Register 0: a request (pipe or aux) with address 0 is a no-op. Pipe: nothing issued. Aux: handshake completes but nothing is pushed.
- Issue, each posedge, priority order:
  - (1) pipe_wr && pipe_addr!=0: rf_* <= pipe request.
  - (2) else if the FIFO head exists: pop. If the head is live, rf_* <= head; if killed, rf_wr <= 0.
  - (3) else rf_wr <= 0.
  - rf_addr and rf_data hold their last value when rf_wr=0.
- Latency:
  - Pipe write reaches rf_* 1 cycle after request.
  - Aux write pushed at edge N issues at edge N+1 at the earliest, and only if no pipe write at N+1.
  - A killed head consumes one issue slot.
- aux_ready = !full, combinational from the registered count.
  - Push and pop at the same edge are allowed when not full. Count is unchanged.
  - No push when full, even if a pop occurs that edge.
- Ordering / WAW rule: when a pipe write to X (X != 0) issues, every queued entry with addr X is marked killed at that edge. Each newly killed entry increments cancel_cnt (see Optional Feature).
  - An aux entry pushed at the same edge as the pipe write to X is NOT killed; the aux is newer.
- Forwarding:
  - fwdN_hit = rf_wr && rf_addr==rd_addrN && rd_addrN!=0.
  - fwdN_data = rf_data.
  - Combinational.
- Busy: busyN = any queued entry that is live with addr==rd_addrN and rd_addrN!=0. Combinational. The entry being issued this cycle still counts as queued until the edge.
- Pointer wrap: read and write pointers are AW bits and wrap modulo DEPTH. Count is AW+1 bits, range 0..DEPTH.

Optional Feature:
- Macro WB_CANCEL_CNT_EN.
- Defined: cancel_cnt counts killed entries. It saturates at 16'hFFFF. If several entries are killed at one edge, it adds the number killed, with saturation.
- Undefined: no counter logic; cancel_cnt is tied to 16'h0000.

Test Plan:
- Reset low mid-queue with 3 entries -> rf_wr=0, aux_ready=1, busy1=busy2=0; after reset release, no write to those addresses ever issues.
- aux push {r5, 32'h1234} with idle pipe -> rf_wr=1, rf_addr=5, rf_data=32'h1234 exactly one edge after the push. rd_addr1=5 sees busy1=1 before issue and fwd1_hit=1 during the issue cycle.
- pipe_wr held every cycle with 4 aux pushes -> aux_ready=0 after the 4th push; a 5th offer is not accepted; queued writes issue in FIFO order once pipe_wr drops.
- Queue {r7, 32'hA} then pipe write {r7, 32'hB} -> rf writes 32'hB only. The killed slot yields a cycle with rf_wr=0; cancel_cnt=1 with WB_CANCEL_CNT_EN, 0 without.
- pipe_wr with pipe_addr=0, and aux push to r0 -> rf_wr never asserts; the aux handshake completes; busy and fwd outputs stay 0 for rd_addr=0.
- Fill/drain 3*DEPTH entries with simultaneous push/pop -> pointer wrap is correct, all data issues in order, count never exceeds DEPTH.
